ioctl_loader: RTL and testbench

IOCTL_LOADER -- requirements
Module: ioctl_loader

---
 rtl/ioctl_loader.sv | 204 ++++++++++++++++++++
 tb/tb_ioctl_loader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader.sv
// ioctl_loader: buffers host download bytes (ROM or RAM image) in a small
// FIFO and replays them as req/ack memory writes, with download status.
// Ports: clk_48, reset (async, active-high); ioctl_download/wr/addr/dout/
// index from host, ioctl_wait back-pressure; mem_req/sel/addr/data out,
// mem_ack in; busy, done pulse, byte_count, checksum, sticky overflow.
module ioctl_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  ROM_INDEX  = 8'h00,
   parameter logic [7:0]  RAM_INDEX  = 8'h01,
   parameter logic [16:0] ROM_SIZE   = 17'h08000,
   parameter logic [15:0] RAM_BASE   = 16'h8000
) (
   input  logic        clk_48,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   output logic        mem_req,
   output logic        mem_sel,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic [15:0] byte_count,
   output logic [7:0]  checksum,
   output logic        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic        sel;
      logic [15:0] addr;
      logic [7:0]  data;
   } entry_t;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_GAP} wstate_t;
   typedef enum logic [1:0] {C_IDLE, C_LOAD, C_DRAIN} cstate_t;

   wstate_t       wstate_q, wstate_d;
   cstate_t       cstate_q, cstate_d;
   entry_t        fifo_q [FIFO_DEPTH];
   entry_t        new_e;
   entry_t        out_q, out_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          dl_prev_q;
   logic          wait_q, wait_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   byte_count_q, byte_count_d;
   logic [7:0]    checksum_q, checksum_d;

   logic rise, idx_rom, idx_ram, strobe, in_range, keep;
   logic full, empty, push, pop, load_out, done_c;

   // Host side: acceptance, entry formation, status counters
   always_comb begin
      rise     = ioctl_download & ~dl_prev_q;
      idx_rom  = (ioctl_index == ROM_INDEX);
      idx_ram  = (ioctl_index == RAM_INDEX);
      // bytes count only inside a recognised window (or its opening cycle)
      strobe   = ioctl_download & ioctl_wr & (idx_rom | idx_ram)
                 & (rise | (cstate_q == C_LOAD));
      in_range = (ioctl_addr < {8'd0, ROM_SIZE});
      keep     = strobe & (~idx_rom | in_range);
      full     = (count_q == CW'(FIFO_DEPTH));
      empty    = (count_q == '0);
      push     = keep & ~full;

      new_e.sel  = ~idx_rom;
      new_e.addr = idx_rom ? ioctl_addr[15:0]
                           : RAM_BASE + ioctl_addr[15:0];
      new_e.data = ioctl_dout;

      byte_count_d = rise ? 16'd0 : byte_count_q;
      checksum_d   = rise ? 8'd0 : checksum_q;
      overflow_d   = ~rise & overflow_q;
      if (push) begin
         if (byte_count_d != 16'hFFFF) begin
            byte_count_d = byte_count_d + 16'd1;
         end
         checksum_d = checksum_d + ioctl_dout;
      end
      if (keep & full) begin
         overflow_d = 1'b1;
      end
   end

   // Write FSM: present head, hold until ack, then one idle gap cycle
   always_comb begin
      wstate_d = wstate_q;
      pop      = 1'b0;
      load_out = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (!empty) begin
               wstate_d = W_REQ;
               load_out = 1'b1;
            end
         end
         W_REQ: begin
            if (mem_ack) begin
               pop      = 1'b1;
               wstate_d = W_GAP;
            end
         end
         W_GAP: begin
            if (!empty) begin
               wstate_d = W_REQ;
               load_out = 1'b1;
            end else begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Pointer and occupancy bookkeeping
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      wait_d   = (count_d >= CW'(FIFO_DEPTH - 1));
      out_d    = load_out ? fifo_q[rd_ptr_q] : out_q;
   end

   // Control FSM: window open, then drain until writer is quiet
   always_comb begin
      cstate_d = cstate_q;
      done_c   = 1'b0;
      case (cstate_q)
         C_IDLE: begin
            if (rise) cstate_d = C_LOAD;
         end
         C_LOAD: begin
            if (!ioctl_download) cstate_d = C_DRAIN;
         end
         C_DRAIN: begin
            if (rise) begin
               cstate_d = C_LOAD;
            end else if (empty && (wstate_q == W_IDLE)) begin
               cstate_d = C_IDLE;
               done_c   = 1'b1;
            end
         end
         default: cstate_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         wstate_q     <= W_IDLE;
         cstate_q     <= C_IDLE;
         out_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         // a download already high at release must not look like an edge
         dl_prev_q    <= 1'b1;
         wait_q       <= 1'b0;
         overflow_q   <= 1'b0;
         byte_count_q <= '0;
         checksum_q   <= '0;
      end else begin
         wstate_q     <= wstate_d;
         cstate_q     <= cstate_d;
         out_q        <= out_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dl_prev_q    <= ioctl_download;
         wait_q       <= wait_d;
         overflow_q   <= overflow_d;
         byte_count_q <= byte_count_d;
         checksum_q   <= checksum_d;
      end
   end

   // Storage needs no reset: pointers and count define validity
   always_ff @(posedge clk_48) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= new_e;
      end
   end

   assign ioctl_wait = wait_q;
   assign mem_req    = (wstate_q == W_REQ);
   assign mem_sel    = out_q.sel;
   assign mem_addr   = out_q.addr;
   assign mem_data   = out_q.data;
   assign busy       = (cstate_q != C_IDLE);
   assign done       = done_c;
   assign byte_count = byte_count_q;
   assign checksum   = checksum_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed and random downloads against a queue-based
// model of the loader, plus literal checks of the headline scenarios.
module tb_ioctl_loader;

   localparam int DEPTH = 4;
   localparam logic [24:0] ROM_LIM = 25'h08000;

   logic        clk_48 = 1'b0;
   logic        reset;
   logic        ioctl_download, ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout, ioctl_index;
   logic        ioctl_wait, mem_req, mem_sel, mem_ack;
   logic [15:0] mem_addr, byte_count;
   logic [7:0]  mem_data, checksum;
   logic        busy, done, overflow;

   ioctl_loader #(
      .FIFO_DEPTH(DEPTH),
      .ROM_INDEX(8'h00),
      .RAM_INDEX(8'h01),
      .ROM_SIZE(17'h08000),
      .RAM_BASE(16'h8000)
   ) dut (
      .clk_48(clk_48),
      .reset(reset),
      .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .ioctl_index(ioctl_index),
      .ioctl_wait(ioctl_wait),
      .mem_req(mem_req),
      .mem_sel(mem_sel),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_ack(mem_ack),
      .busy(busy),
      .done(done),
      .byte_count(byte_count),
      .checksum(checksum),
      .overflow(overflow)
   );

   always #5 clk_48 = ~clk_48;

   typedef struct {
      logic        sel;
      logic [15:0] addr;
      logic [7:0]  data;
      int          pc;
   } ment_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // model state
   ment_t mq[$];
   int    last_pop;
   int    m_count, m_sum;
   bit    m_ovf, m_prev_dl, m_win, m_drain;

   // observations
   logic [24:0] wlog[$];
   int          rq[$];
   int          done_cnt, done_cyc, last_req_cyc;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic logic [24:0] wl(input int i);
      if (i < wlog.size()) return wlog[i];
      return '1;
   endfunction

   task automatic model_reset();
      mq.delete();
      last_pop  = -100;
      m_count   = 0;
      m_sum     = 0;
      m_ovf     = 0;
      m_prev_dl = 1;
      m_win     = 0;
      m_drain   = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wait"}, ioctl_wait, 0);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_sel"}, mem_sel, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_data"}, mem_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_count"}, byte_count, 0);
      chk({tag, "_sum"}, checksum, 0);
      chk({tag, "_ovf"}, overflow, 0);
   endtask

   // called at posedge+1; asserts reset and checks outputs right away
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk_zero(tag);
      repeat (2) @(posedge clk_48);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // one clock cycle: compare at negedge, advance the model, move on
   task automatic tick();
      bit    rise, req, done_e, acc, keep, full;
      int    occ;
      ment_t e;
      @(negedge clk_48);
      occ  = mq.size();
      rise = ioctl_download && !m_prev_dl;
      req  = 0;
      if (occ > 0) begin
         req = (mq[0].pc <= cyc - 2) && (cyc >= last_pop + 2);
      end
      done_e = m_drain && !rise && (occ == 0) && (cyc != last_pop + 1);

      chk("mem_req", mem_req, req);
      if (req) begin
         chk("mem_sel", mem_sel, mq[0].sel);
         chk("mem_addr", mem_addr, mq[0].addr);
         chk("mem_data", mem_data, mq[0].data);
      end
      chk("ioctl_wait", ioctl_wait, occ >= DEPTH - 1);
      chk("busy", busy, m_win || m_drain);
      chk("done", done, done_e);
      chk("byte_count", byte_count, m_count);
      chk("checksum", checksum, m_sum);
      chk("overflow", overflow, m_ovf);

      if (mem_req && mem_ack) begin
         wlog.push_back({mem_sel, mem_addr, mem_data});
         last_req_cyc = cyc;
      end
      if (mem_req) rq.push_back(cyc);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end

      full = (occ >= DEPTH);
      if (req && mem_ack) begin
         void'(mq.pop_front());
         last_pop = cyc;
      end
      if (rise) begin
         m_count = 0;
         m_sum   = 0;
         m_ovf   = 0;
      end
      acc = ioctl_download && ioctl_wr && (rise || m_win)
            && (ioctl_index == 8'h00 || ioctl_index == 8'h01);
      if (acc) begin
         keep = (ioctl_index == 8'h01) || (ioctl_addr < ROM_LIM);
         if (keep && full) begin
            m_ovf = 1;
         end else if (keep) begin
            e.sel  = (ioctl_index == 8'h01);
            e.addr = e.sel ? 16'h8000 + ioctl_addr[15:0] : ioctl_addr[15:0];
            e.data = ioctl_dout;
            e.pc   = cyc;
            mq.push_back(e);
            if (m_count < 65535) m_count++;
            m_sum = (m_sum + int'(ioctl_dout)) % 256;
         end
      end
      if (rise) begin
         m_win   = 1;
         m_drain = 0;
      end else if (m_win && !ioctl_download) begin
         m_win   = 0;
         m_drain = 1;
      end else if (done_e) begin
         m_drain = 0;
      end
      m_prev_dl = ioctl_download;
      cyc++;
      @(posedge clk_48);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a,
                          input logic [7:0] d);
      ioctl_wr    = 1'b1;
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_done(input string nm, input int budget);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < budget) begin
         tick();
         k++;
      end
      chk(nm, done_cnt > start, 1);
   endtask

   task automatic scen_start();
      wlog.delete();
      rq.delete();
      done_cnt = 0;
      done_cyc = 0;
      last_req_cyc = 0;
   endtask

   task automatic rand_cycle();
      mem_ack  = ($urandom_range(0, 3) != 0);
      ioctl_wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0:       ioctl_index = 8'h00;
         3:       ioctl_index = 8'h02;
         default: ioctl_index = 8'h01;
      endcase
      if ($urandom_range(0, 1) == 1)
         ioctl_addr = 25'h07FF0 + 25'($urandom_range(0, 31));
      else
         ioctl_addr = 25'($urandom());
      ioctl_dout = 8'($urandom());
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      mem_ack        = 1'b0;
      model_reset();
      @(posedge clk_48);
      #1;
      do_reset("rst0");
      idle(3);

      // RAM image of three bytes, ack always high
      scen_start();
      mem_ack = 1'b1;
      ioctl_download = 1'b1;
      wr_byte(8'h01, 25'h0, 8'h11);
      wr_byte(8'h01, 25'h1, 8'h22);
      wr_byte(8'h01, 25'h2, 8'h33);
      ioctl_download = 1'b0;
      wait_done("ram3_done", 40);
      idle(4);
      chk("ram3_nwr", wlog.size(), 3);
      chk("ram3_w0", wl(0), {1'b1, 16'h8000, 8'h11});
      chk("ram3_w1", wl(1), {1'b1, 16'h8001, 8'h22});
      chk("ram3_w2", wl(2), {1'b1, 16'h8002, 8'h33});
      chk("ram3_nreq", rq.size(), 3);
      if (rq.size() == 3) begin
         chk("ram3_gap0", rq[1] - rq[0], 2);
         chk("ram3_gap1", rq[2] - rq[1], 2);
      end
      chk("ram3_count", byte_count, 3);
      chk("ram3_sum", checksum, 8'h66);
      chk("ram3_ndone", done_cnt, 1);
      d = done_cyc - last_req_cyc;
      chk("ram3_done_after", (d >= 1 && d <= 2), 1);

      // ROM boundary
      scen_start();
      ioctl_download = 1'b1;
      tick();
      wr_byte(8'h00, 25'h07FFF, 8'hA5);
      wr_byte(8'h00, 25'h08000, 8'h5A);
      ioctl_download = 1'b0;
      wait_done("rom_done", 40);
      idle(3);
      chk("rom_nwr", wlog.size(), 1);
      chk("rom_w0", wl(0), {1'b0, 16'h7FFF, 8'hA5});
      chk("rom_count", byte_count, 1);
      chk("rom_sum", checksum, 8'hA5);

      // back-pressure and overflow
      scen_start();
      mem_ack = 1'b0;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         wr_byte(8'h01, 25'(i), 8'(8'h10 + i));
         if (i == 1) chk("bp_wait_lo", ioctl_wait, 0);
         if (i == 2) chk("bp_wait_hi", ioctl_wait, 1);
      end
      chk("bp_ovf", overflow, 1);
      chk("bp_count", byte_count, 4);
      mem_ack = 1'b1;
      ioctl_download = 1'b0;
      wait_done("bp_done", 60);
      idle(2);
      chk("bp_nwr", wlog.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("bp_w", wl(i), {1'b1, 16'(16'h8000 + i), 8'(8'h10 + i)});
      chk("bp_wait_end", ioctl_wait, 0);

      // RAM wrap and foreign index
      scen_start();
      ioctl_download = 1'b1;
      tick();
      wr_byte(8'h01, 25'h0FFFF, 8'h77);
      wr_byte(8'h02, 25'h00010, 8'h99);
      ioctl_download = 1'b0;
      wait_done("wrap_done", 40);
      idle(2);
      chk("wrap_nwr", wlog.size(), 1);
      chk("wrap_w0", wl(0), {1'b1, 16'h7FFF, 8'h77});
      chk("wrap_count", byte_count, 1);
      chk("wrap_sum", checksum, 8'h77);

      // reset while a request is pending, download left high
      scen_start();
      mem_ack = 1'b0;
      ioctl_download = 1'b1;
      tick();
      wr_byte(8'h01, 25'h3, 8'h44);
      tick();
      chk("rstm_req_before", mem_req, 1);
      do_reset("rstm");
      idle(6);
      chk("rstm_busy", busy, 0);
      chk("rstm_ndone", done_cnt, 0);
      chk("rstm_nwr", wlog.size(), 0);
      ioctl_download = 1'b0;
      idle(2);

      // second window opening while draining
      scen_start();
      mem_ack = 1'b0;
      ioctl_download = 1'b1;
      tick();
      wr_byte(8'h01, 25'h10, 8'hA1);
      wr_byte(8'h01, 25'h11, 8'hA2);
      ioctl_download = 1'b0;
      idle(3);
      chk("re_busy_drain", busy, 1);
      ioctl_download = 1'b1;
      tick();
      chk("re_count_clr", byte_count, 0);
      wr_byte(8'h01, 25'h20, 8'hB1);
      mem_ack = 1'b1;
      ioctl_download = 1'b0;
      wait_done("re_done", 60);
      idle(5);
      chk("re_ndone", done_cnt, 1);
      chk("re_nwr", wlog.size(), 3);
      chk("re_w0", wl(0), {1'b1, 16'h8010, 8'hA1});
      chk("re_w1", wl(1), {1'b1, 16'h8011, 8'hA2});
      chk("re_w2", wl(2), {1'b1, 16'h8020, 8'hB1});
      chk("re_count", byte_count, 1);
      chk("re_sum", checksum, 8'hB1);

      // random windows against the model
      for (int w = 0; w < 40; w++) begin
         int len;
         int dr;
         len = $urandom_range(4, 30);
         ioctl_download = 1'b1;
         for (int k = 0; k < len; k++) rand_cycle();
         ioctl_wr = 1'b0;
         ioctl_download = 1'b0;
         dr = $urandom_range(1, 25);
         for (int k = 0; k < dr; k++) begin
            mem_ack = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      mem_ack = 1'b1;
      idle(60);
      chk("rand_end_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
